// File: rtl/sha2_compress_core.sv
// SHA-256 / SHA-512 compression core: one round per clock, with round constants read from an external synchronous ROM.
// Optional macro SHA2_CHAIN_EN adds the chaining register so that multi-block messages can be hashed.
module sha2_compress_core #(
    parameter int WORDSIZE = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [16*WORDSIZE-1:0] in_block,
    input  logic                   in_first,
    output logic [6:0]             k_round,
    input  logic [WORDSIZE-1:0]    k_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [8*WORDSIZE-1:0]  digest
);
    localparam int ROUNDS = (WORDSIZE == 32) ? 64 : 80;
    localparam logic [6:0] LAST_ROUND = 7'(ROUNDS - 1);

    localparam int BS0_A = (WORDSIZE == 32) ? 2  : 28;
    localparam int BS0_B = (WORDSIZE == 32) ? 13 : 34;
    localparam int BS0_C = (WORDSIZE == 32) ? 22 : 39;
    localparam int BS1_A = (WORDSIZE == 32) ? 6  : 14;
    localparam int BS1_B = (WORDSIZE == 32) ? 11 : 18;
    localparam int BS1_C = (WORDSIZE == 32) ? 25 : 41;
    localparam int SS0_A = (WORDSIZE == 32) ? 7  : 1;
    localparam int SS0_B = (WORDSIZE == 32) ? 18 : 8;
    localparam int SS0_S = (WORDSIZE == 32) ? 3  : 7;
    localparam int SS1_A = (WORDSIZE == 32) ? 17 : 19;
    localparam int SS1_B = (WORDSIZE == 32) ? 19 : 61;
    localparam int SS1_S = (WORDSIZE == 32) ? 10 : 6;

    localparam logic [255:0] IV_256 = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [511:0] IV_512 = 512'h6a09e667f3bcc908_bb67ae8584caa73b_3c6ef372fe94f82b_a54ff53a5f1d36f1_510e527fade682d1_9b05688c2b3e6c1f_1f83d9abfb41bd6b_5be0cd19137e2179;
    localparam logic [511:0] IV_ALL = (WORDSIZE == 32) ? {256'd0, IV_256} : IV_512;
    localparam logic [0:7][WORDSIZE-1:0] IV = IV_ALL[8*WORDSIZE-1:0];

    generate
        if (WORDSIZE != 32 && WORDSIZE != 64) begin : g_bad_wordsize
            $error("sha2_compress_core: WORDSIZE must be 32 or 64");
        end
    endgenerate

    function automatic logic [WORDSIZE-1:0] rotr(input logic [WORDSIZE-1:0] x, input int n);
        return (x >> n) | (x << (WORDSIZE - n));
    endfunction

    function automatic logic [WORDSIZE-1:0] big_sigma0(input logic [WORDSIZE-1:0] x);
        return rotr(x, BS0_A) ^ rotr(x, BS0_B) ^ rotr(x, BS0_C);
    endfunction

    function automatic logic [WORDSIZE-1:0] big_sigma1(input logic [WORDSIZE-1:0] x);
        return rotr(x, BS1_A) ^ rotr(x, BS1_B) ^ rotr(x, BS1_C);
    endfunction

    function automatic logic [WORDSIZE-1:0] small_sigma0(input logic [WORDSIZE-1:0] x);
        return rotr(x, SS0_A) ^ rotr(x, SS0_B) ^ (x >> SS0_S);
    endfunction

    function automatic logic [WORDSIZE-1:0] small_sigma1(input logic [WORDSIZE-1:0] x);
        return rotr(x, SS1_A) ^ rotr(x, SS1_B) ^ (x >> SS1_S);
    endfunction

    function automatic logic [WORDSIZE-1:0] ch(input logic [WORDSIZE-1:0] x, y, z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [WORDSIZE-1:0] maj(input logic [WORDSIZE-1:0] x, y, z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ROUND = 3'd2,
        S_FINAL = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                      state_r, state_s;
    logic [6:0]                  round_r, round_s;
    logic                        in_ready_r, in_ready_s;
    logic                        out_valid_r, out_valid_s;
    logic [6:0]                  k_round_r, k_round_s;
    logic [0:15][WORDSIZE-1:0]   win_r;
    logic [0:7][WORDSIZE-1:0]    wv_r, wv_s, hsel_s, hbase_s, sum_s;
    logic [WORDSIZE-1:0]         t1_s, t2_s, w_new_s;
    logic [8*WORDSIZE-1:0]       digest_r;

    // State register plus registered handshake and ROM-index outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            round_r     <= 7'd0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            k_round_r   <= 7'd0;
        end else begin
            state_r     <= state_s;
            round_r     <= round_s;
            in_ready_r  <= in_ready_s;
            out_valid_r <= out_valid_s;
            k_round_r   <= k_round_s;
        end
    end

    // Next-state and round-counter logic
    always_comb begin
        state_s = state_r;
        round_s = round_r;
        case (state_r)
            S_IDLE: begin
                if (in_valid) state_s = S_LOAD;
                else          state_s = S_IDLE;
            end
            S_LOAD: begin
                state_s = S_ROUND;
                round_s = 7'd0;
            end
            S_ROUND: begin
                if (round_r == LAST_ROUND) begin
                    state_s = S_FINAL;
                    round_s = 7'd0;
                end else begin
                    state_s = S_ROUND;
                    round_s = round_r + 7'd1;
                end
            end
            S_FINAL: state_s = S_DONE;
            S_DONE: begin
                if (out_ready) state_s = S_IDLE;
                else           state_s = S_DONE;
            end
            default: begin
                state_s = S_IDLE;
                round_s = 7'd0;
            end
        endcase
    end

    // Output decode from the upcoming state; k_round runs one round ahead for the sync ROM
    always_comb begin
        in_ready_s  = (state_s == S_IDLE);
        out_valid_s = (state_s == S_DONE);
        if (state_s == S_ROUND) k_round_s = round_s + 7'd1;
        else                    k_round_s = 7'd0;
    end

`ifdef SHA2_CHAIN_EN
    logic [0:7][WORDSIZE-1:0] chain_r;
    logic                     first_r;

    assign hsel_s  = in_first ? IV : chain_r;
    assign hbase_s = first_r  ? IV : chain_r;

    // Chaining register: reset to IV so an unchained first block still starts from IV
    always_ff @(posedge clk) begin
        if (rst) begin
            chain_r <= IV;
            first_r <= 1'b1;
        end else if (state_r == S_IDLE && in_valid) begin
            first_r <= in_first;
        end else if (state_r == S_FINAL) begin
            chain_r <= sum_s;
        end
    end
`else
    logic unused_in_first_s;

    assign unused_in_first_s = in_first;
    assign hsel_s            = IV;
    assign hbase_s           = IV;
`endif

    // One compression round, next schedule word, and the final feed-forward sum
    always_comb begin
        t1_s    = wv_r[7] + big_sigma1(wv_r[4]) + ch(wv_r[4], wv_r[5], wv_r[6]) + k_in + win_r[0];
        t2_s    = big_sigma0(wv_r[0]) + maj(wv_r[0], wv_r[1], wv_r[2]);
        wv_s    = {t1_s + t2_s, wv_r[0], wv_r[1], wv_r[2], wv_r[3] + t1_s, wv_r[4], wv_r[5], wv_r[6]};
        w_new_s = small_sigma1(win_r[14]) + win_r[9] + small_sigma0(win_r[1]) + win_r[0];
        for (int i = 0; i < 8; i++) begin
            sum_s[i] = hbase_s[i] + wv_r[i];
        end
    end

    // Working variables, sliding 16-word schedule window and digest register
    always_ff @(posedge clk) begin
        if (rst) begin
            win_r    <= '0;
            wv_r     <= '0;
            digest_r <= '0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (in_valid) begin
                        win_r <= in_block;
                        wv_r  <= hsel_s;
                    end
                end
                S_ROUND: begin
                    wv_r  <= wv_s;
                    win_r <= {win_r[1:15], w_new_s};
                end
                S_FINAL: digest_r <= sum_s;
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign k_round   = k_round_r;
    assign digest    = digest_r;
endmodule

// File: tb/tb_sha2_compress_core.sv
// Bench for sha2_compress_core: SHA-256 and SHA-512 instances checked against a reference model whose
// round constants and IV are derived from prime roots; honours SHA2_CHAIN_EN when it is defined.
module tb_sha2_compress_core;
`ifdef SHA2_CHAIN_EN
    localparam bit CHAIN_EN = 1'b1;
`else
    localparam bit CHAIN_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_a, in_valid_a, in_ready_a, in_first_a, out_valid_a, out_ready_a;
    logic [511:0] in_block_a;
    logic [6:0]   k_round_a;
    logic [31:0]  k_in_a;
    logic [255:0] digest_a;

    logic          rst_b, in_valid_b, in_ready_b, in_first_b, out_valid_b, out_ready_b;
    logic [1023:0] in_block_b;
    logic [6:0]    k_round_b;
    logic [63:0]   k_in_b;
    logic [511:0]  digest_b;

    sha2_compress_core #(.WORDSIZE(32)) dut_a (
        .clk(clk), .rst(rst_a), .in_valid(in_valid_a), .in_ready(in_ready_a), .in_block(in_block_a),
        .in_first(in_first_a), .k_round(k_round_a), .k_in(k_in_a), .out_valid(out_valid_a),
        .out_ready(out_ready_a), .digest(digest_a)
    );

    sha2_compress_core #(.WORDSIZE(64)) dut_b (
        .clk(clk), .rst(rst_b), .in_valid(in_valid_b), .in_ready(in_ready_b), .in_block(in_block_b),
        .in_first(in_first_b), .k_round(k_round_b), .k_in(k_in_b), .out_valid(out_valid_b),
        .out_ready(out_ready_b), .digest(digest_b)
    );

    logic [63:0]      k_tab [80];
    logic [0:7][63:0] iv_tab;
    logic [0:7][63:0] chain_a, chain_b;
    int checks = 0;
    int errors = 0;

    // Synchronous-read constant ROMs, one per instance
    always @(posedge clk) k_in_a <= (k_round_a < 7'd64) ? k_tab[k_round_a][63:32] : 32'd0;
    always @(posedge clk) k_in_b <= (k_round_b < 7'd80) ? k_tab[k_round_b] : 64'd0;

    // floor of frac(p^(1/deg)) * 2^64, by bitwise integer root search
    function automatic logic [63:0] frac_root(int p, int deg);
        logic [255:0] n, r, c, pw;
        n = 256'(p) << (64 * deg);
        r = 256'd0;
        for (int b = 68; b >= 0; b--) begin
            c  = r | (256'd1 << b);
            pw = (deg == 3) ? c * c * c : c * c;
            if (pw <= n) r = c;
        end
        return r[63:0];
    endfunction

    function automatic logic [63:0] rotr(int ws, logic [63:0] x, int n);
        logic [63:0] msk;
        msk = (ws == 32) ? 64'h0000_0000_ffff_ffff : 64'hffff_ffff_ffff_ffff;
        return ((x >> n) | (x << (ws - n))) & msk;
    endfunction

    function automatic logic [0:7][63:0] ref_compress(int ws, logic [0:7][63:0] h, logic [0:15][63:0] m);
        logic [63:0] msk, s0, s1, bs0, bs1, chv, majv, kt, t1, t2;
        logic [63:0] w [80];
        logic [63:0] v [8];
        logic [0:7][63:0] r;
        int rounds;
        msk    = (ws == 32) ? 64'h0000_0000_ffff_ffff : 64'hffff_ffff_ffff_ffff;
        rounds = (ws == 32) ? 64 : 80;
        for (int t = 0; t < rounds; t++) begin
            if (t < 16) begin
                w[t] = m[t];
            end else begin
                if (ws == 32) begin
                    s0 = rotr(32, w[t-15], 7) ^ rotr(32, w[t-15], 18) ^ (w[t-15] >> 3);
                    s1 = rotr(32, w[t-2], 17) ^ rotr(32, w[t-2], 19) ^ (w[t-2] >> 10);
                end else begin
                    s0 = rotr(64, w[t-15], 1) ^ rotr(64, w[t-15], 8) ^ (w[t-15] >> 7);
                    s1 = rotr(64, w[t-2], 19) ^ rotr(64, w[t-2], 61) ^ (w[t-2] >> 6);
                end
                w[t] = (s1 + w[t-7] + s0 + w[t-16]) & msk;
            end
        end
        for (int i = 0; i < 8; i++) v[i] = h[i];
        for (int t = 0; t < rounds; t++) begin
            if (ws == 32) begin
                bs1 = rotr(32, v[4], 6) ^ rotr(32, v[4], 11) ^ rotr(32, v[4], 25);
                bs0 = rotr(32, v[0], 2) ^ rotr(32, v[0], 13) ^ rotr(32, v[0], 22);
                kt  = k_tab[t] >> 32;
            end else begin
                bs1 = rotr(64, v[4], 14) ^ rotr(64, v[4], 18) ^ rotr(64, v[4], 41);
                bs0 = rotr(64, v[0], 28) ^ rotr(64, v[0], 34) ^ rotr(64, v[0], 39);
                kt  = k_tab[t];
            end
            chv  = ((v[4] & v[5]) ^ (~v[4] & v[6])) & msk;
            majv = (v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]);
            t1   = (v[7] + bs1 + chv + kt + w[t]) & msk;
            t2   = (bs0 + majv) & msk;
            v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = (v[3] + t1) & msk;
            v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = (t1 + t2) & msk;
        end
        for (int i = 0; i < 8; i++) r[i] = (h[i] + v[i]) & msk;
        return r;
    endfunction

    function automatic logic [0:7][63:0] iv_for(int ws);
        logic [0:7][63:0] r;
        for (int i = 0; i < 8; i++) r[i] = (ws == 32) ? (iv_tab[i] >> 32) : iv_tab[i];
        return r;
    endfunction

    function automatic logic [1023:0] pack_block(int ws, logic [0:15][63:0] m);
        logic [1023:0] v;
        v = 1024'd0;
        for (int j = 0; j < 16; j++) begin
            if (ws == 32) v[511-32*j -: 32]  = m[j][31:0];
            else          v[1023-64*j -: 64] = m[j];
        end
        return v;
    endfunction

    function automatic logic [0:7][63:0] unpack_digest(int ws, logic [511:0] d);
        logic [0:7][63:0] r;
        for (int i = 0; i < 8; i++) begin
            if (ws == 32) r[i] = {32'd0, d[255-32*i -: 32]};
            else          r[i] = d[511-64*i -: 64];
        end
        return r;
    endfunction

    function automatic logic [0:15][63:0] rand_block(int ws);
        logic [0:15][63:0] m;
        for (int j = 0; j < 16; j++) m[j] = (ws == 32) ? {32'd0, $urandom} : {$urandom, $urandom};
        return m;
    endfunction

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input int ws, input string tag);
        if (ws == 32) begin
            check({tag, "_in_ready"}, in_ready_a, 1);
            check({tag, "_out_valid"}, out_valid_a, 0);
            check({tag, "_digest"}, digest_a, 0);
            check({tag, "_k_round"}, k_round_a, 0);
        end else begin
            check({tag, "_in_ready"}, in_ready_b, 1);
            check({tag, "_out_valid"}, out_valid_b, 0);
            check({tag, "_digest"}, digest_b, 0);
            check({tag, "_k_round"}, k_round_b, 0);
        end
    endtask

    // Offer a block at a negedge; returns at the negedge of the LOAD cycle
    task automatic start_block(input int ws, input logic [0:15][63:0] m, input logic first);
        logic [1023:0] v;
        v = pack_block(ws, m);
        check("idle_in_ready", (ws == 32) ? in_ready_a : in_ready_b, 1);
        if (ws == 32) begin
            in_block_a = v[511:0]; in_first_a = first; in_valid_a = 1'b1;
        end else begin
            in_block_b = v; in_first_b = first; in_valid_b = 1'b1;
        end
        @(negedge clk);
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
        check("load_in_ready", (ws == 32) ? in_ready_a : in_ready_b, 0);
        check("load_k_round", (ws == 32) ? k_round_a : k_round_b, 0);
    endtask

    // Expected digest from the model, then send, wait for out_valid and check latency and digest
    task automatic run_to_done(input int ws, input logic [0:15][63:0] m, input logic first,
                               input string tag, output logic [0:7][63:0] dg);
        logic [0:7][63:0] h, exp;
        int c;
        if (CHAIN_EN && !first) h = (ws == 32) ? chain_a : chain_b;
        else                    h = iv_for(ws);
        exp = ref_compress(ws, h, m);
        if (ws == 32) chain_a = exp;
        else          chain_b = exp;
        start_block(ws, m, first);
        c = 1;
        while (((ws == 32) ? out_valid_a : out_valid_b) !== 1'b1 && c < 300) begin
            @(negedge clk);
            c++;
        end
        check({tag, "_latency"}, c, (ws == 32) ? 67 : 83);
        dg = (ws == 32) ? unpack_digest(32, {256'd0, digest_a}) : unpack_digest(64, digest_b);
        check({tag, "_digest"}, dg, exp);
    endtask

    task automatic ack(input int ws);
        if (ws == 32) out_ready_a = 1'b1;
        else          out_ready_b = 1'b1;
        @(negedge clk);
        out_ready_a = 1'b0;
        out_ready_b = 1'b0;
        check("ack_out_valid", (ws == 32) ? out_valid_a : out_valid_b, 0);
        check("ack_in_ready", (ws == 32) ? in_ready_a : in_ready_b, 1);
    endtask

    initial begin
        int primes [80];
        int np;
        logic [0:15][63:0] m, m2;
        logic [0:7][63:0] dg;
        logic [255:0] hold;

        np = 0;
        for (int c = 2; np < 80; c++) begin
            bit isp;
            isp = 1'b1;
            for (int d = 2; d * d <= c; d++) if (c % d == 0) isp = 1'b0;
            if (isp) begin
                primes[np] = c;
                np++;
            end
        end
        for (int i = 0; i < 80; i++) k_tab[i] = frac_root(primes[i], 3);
        for (int i = 0; i < 8; i++) iv_tab[i] = frac_root(primes[i], 2);
        chain_a = iv_for(32);
        chain_b = iv_for(64);

        rst_a = 1'b1; in_valid_a = 1'b0; in_first_a = 1'b0; out_ready_a = 1'b0; in_block_a = 512'd0;
        rst_b = 1'b1; in_valid_b = 1'b0; in_first_b = 1'b0; out_ready_b = 1'b0; in_block_b = 1024'd0;
        repeat (2) @(negedge clk);
        check_reset(32, "reset_a");
        check_reset(64, "reset_b");
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);

        // "abc" known answers
        m = '0; m[0] = 64'h6162_6380; m[15] = 64'h18;
        run_to_done(32, m, 1'b1, "abc256", dg);
        check("abc256_h0", dg[0], 64'hba78_16bf);
        check("abc256_h7", dg[7], 64'hf200_15ad);
        ack(32);
        m = '0; m[0] = 64'h6162_6380_0000_0000; m[15] = 64'h18;
        run_to_done(64, m, 1'b1, "abc512", dg);
        check("abc512_h0_hi", dg[0][63:32], 64'hddaf_35a1);
        check("abc512_h7_lo", dg[7][31:0], 64'ha54c_a49f);
        ack(64);

        // Random blocks with random in_first
        for (int i = 0; i < 4; i++) begin
            run_to_done(32, rand_block(32), 1'($urandom_range(1)), "rand256", dg);
            ack(32);
        end
        for (int i = 0; i < 2; i++) begin
            run_to_done(64, rand_block(64), 1'($urandom_range(1)), "rand512", dg);
            ack(64);
        end

        // Two-block message: second digest is the chained result, or the block hashed from IV
        m = '0;
        for (int i = 0; i < 14; i++) m[i] = {32'd0, 8'(8'h61 + i), 8'(8'h62 + i), 8'(8'h63 + i), 8'(8'h64 + i)};
        m[14] = 64'h8000_0000;
        m2 = '0; m2[15] = 64'h1c0;
        run_to_done(32, m, 1'b1, "two_blk1", dg);
        ack(32);
        run_to_done(32, m2, 1'b0, "two_blk2", dg);
`ifdef SHA2_CHAIN_EN
        check("two_blk_h0", dg[0], 64'h248d_6a61);
        check("two_blk_h7", dg[7], 64'h19db_06c1);
`endif
        ack(32);

        // Back-pressure in DONE while a new block is offered
        run_to_done(32, rand_block(32), 1'b1, "bp", dg);
        hold = digest_a;
        m = rand_block(32);
        in_block_a = pack_block(32, m)[511:0];
        in_first_a = 1'b1;
        in_valid_a = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("bp_digest", digest_a, hold);
            check("bp_in_ready", in_ready_a, 0);
            check("bp_out_valid", out_valid_a, 1);
        end
        in_valid_a = 1'b0;
        ack(32);
        repeat (5) @(negedge clk);
        check("bp_no_accept_out_valid", out_valid_a, 0);
        check("bp_no_accept_in_ready", in_ready_a, 1);

        // Reset during round 30 aborts the block and restores the IV chain
        start_block(32, rand_block(32), 1'b0);
        repeat (31) @(negedge clk);
        check("round30_k_round", k_round_a, 31);
        rst_a = 1'b1;
        @(negedge clk);
        check_reset(32, "midrst");
        rst_a = 1'b0;
        chain_a = iv_for(32);
        @(negedge clk);
        check("midrst_idle_out_valid", out_valid_a, 0);
        m = '0; m[0] = 64'h6162_6380; m[15] = 64'h18;
        run_to_done(32, m, 1'b0, "abc_after_rst", dg);
        check("abc_after_rst_h0", dg[0], 64'hba78_16bf);
        check("abc_after_rst_h7", dg[7], 64'hf200_15ad);
        ack(32);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
